// File: rtl/ov7670_capture_if.sv
// Camera-side byte bus and frame-buffer write-side signals of the OV7670 capture stage.
// The write side is a valid-only stream: sys_we qualifies sys_data_in for exactly one clock and the FIFO has no ready.
interface ov7670_capture_if;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        sys_we;
    logic [15:0] sys_data_in;
    logic        frame_valid;
    logic        frame_done;
    logic        size_err;
    logic [1:0]  dbg_state;

    modport master (
        input  cam_vsync, cam_href, cam_data,
        output sys_we, sys_data_in, frame_valid, frame_done, size_err, dbg_state
    );

    modport slave (
        output cam_vsync, cam_href, cam_data,
        input  sys_we, sys_data_in, frame_valid, frame_done, size_err, dbg_state
    );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: registers the camera bus on PCLK and pairs bytes into RGB565 words.
// It writes the words to the SDRAM frame buffer only after init and the skip frames, always starting on a frame boundary.
module ov7670_capture #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic sdram_init_done,
    ov7670_capture_if.master bus
);
    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        WAIT_VS   = 2'd1,
        SKIP      = 2'd2,
        CAPTURE   = 2'd3
    } state_t;

    localparam int              SKW  = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [10:0]     W_L  = 11'(IMG_W);
    localparam logic [9:0]      H_L  = 10'(IMG_H);
    localparam logic [SKW-1:0]  SK_L = SKW'(SKIP_FRAMES);

    logic           vs_r, hr_r, vs_d, hr_d;
    logic [7:0]     d_r;
    logic           init_m, init_s;
    state_t         state, state_nx;
    logic [SKW-1:0] skip_cnt, skip_cnt_inc;
    logic           skip_done, skip_hit;
    logic           phase, phase_eff, pend;
    logic [7:0]     hi_byte;
    logic [15:0]    pend_data;
    logic [10:0]    pix_cnt, pix_eff;
    logic [9:0]     line_cnt, line_nx;
    logic           vs_fall, vs_rise, hr_rise, hr_fall;
    logic           capturing, line_bad, frame_bad;

    assign vs_fall      = vs_d & ~vs_r;
    assign vs_rise      = ~vs_d & vs_r;
    assign hr_rise      = ~hr_d & hr_r;
    assign hr_fall      = hr_d & ~hr_r;
    assign capturing    = (state == CAPTURE);
    assign skip_cnt_inc = skip_cnt + SKW'(1);
    assign bus.dbg_state = state;

    // A new line starts with byte phase and pixel index both at zero on its first byte.
    assign phase_eff = hr_rise ? 1'b0 : phase;
    assign pix_eff   = hr_rise ? 11'd0 : pix_cnt;
    assign line_nx   = (hr_fall && line_cnt != 10'h3FF) ? line_cnt + 10'd1 : line_cnt;

    // The frame check sees the line that ends in the same cycle.
    assign line_bad  = capturing && hr_fall && ((pix_cnt != W_L) || phase);
    assign frame_bad = capturing && vs_rise && (line_nx != H_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_r   <= 1'b0;
            hr_r   <= 1'b0;
            vs_d   <= 1'b0;
            hr_d   <= 1'b0;
            d_r    <= 8'd0;
            init_m <= 1'b0;
            init_s <= 1'b0;
        end else begin
            vs_r   <= bus.cam_vsync;
            hr_r   <= bus.cam_href;
            d_r    <= bus.cam_data;
            vs_d   <= vs_r;
            hr_d   <= hr_r;
            init_m <= sdram_init_done;
            init_s <= init_m;
        end
    end

    always_comb begin
        state_nx = state;
        skip_hit = 1'b0;
        case (state)
            WAIT_INIT: if (init_s) state_nx = WAIT_VS;
            WAIT_VS:   if (vs_fall) state_nx = ((SKIP_FRAMES == 0) || skip_done) ? CAPTURE : SKIP;
            SKIP: begin
                if (vs_rise && (skip_cnt_inc == SK_L)) begin
                    state_nx = WAIT_VS;
                    skip_hit = 1'b1;
                end
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_INIT;
            skip_cnt  <= '0;
            skip_done <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == SKIP && vs_rise && !skip_hit) skip_cnt <= skip_cnt_inc;
            if (skip_hit) begin
                skip_cnt  <= skip_cnt_inc;
                skip_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase           <= 1'b0;
            hi_byte         <= 8'd0;
            pend            <= 1'b0;
            pend_data       <= 16'd0;
            pix_cnt         <= 11'd0;
            line_cnt        <= 10'd0;
            bus.sys_we      <= 1'b0;
            bus.sys_data_in <= 16'd0;
            bus.frame_valid <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.size_err    <= 1'b0;
        end else begin
            pend <= 1'b0;
            if (vs_fall) line_cnt <= 10'd0;
            else         line_cnt <= line_nx;
            if (hr_r) begin
                phase   <= ~phase_eff;
                pix_cnt <= pix_eff;
                if (!phase_eff) begin
                    hi_byte <= d_r;
                end else begin
                    pend_data <= {hi_byte, d_r};
                    pend      <= capturing && (pix_eff < W_L) && (line_cnt < H_L);
                    if (pix_eff != 11'h7FF) pix_cnt <= pix_eff + 11'd1;
                end
            end
            bus.sys_we <= pend;
            if (pend) bus.sys_data_in <= pend_data;
            if (state_nx == CAPTURE && state != CAPTURE) bus.frame_valid <= 1'b1;
            bus.frame_done <= capturing && vs_rise;
            if (line_bad || frame_bad) bus.size_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a 4x4 image with two skip frames: random frame stimulus,
// an expected-word queue with due cycles, and frame-level qualification/size-error model.
module tb_ov7670_capture;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int SK = 2;

  logic clk;
  logic rst;
  logic sdram_init_done;

  ov7670_capture_if bus();

  ov7670_capture #(.IMG_W(W), .IMG_H(H), .SKIP_FRAMES(SK)) dut (
    .clk(clk),
    .rst(rst),
    .sdram_init_done(sdram_init_done),
    .bus(bus)
  );

  int total;
  int bad;
  int cyc;
  int got_we;
  int got_done;
  logic [15:0] exp_q[$];
  int due_q[$];
  logic prev_we;
  logic prev_done;
  logic [15:0] last_data;
  bit m_init;
  bit m_fv;
  bit m_err;
  int m_fidx;
  int m_done;
  bit tight_end;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every strobe must match the next expected word at its due cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.sys_we === 1'b1) begin
        got_we++;
        chk("we_gap", 32'(prev_we), 32'd0);
        chk("we_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("data", 32'(bus.sys_data_in), 32'(exp_q.pop_front()));
          chk("latency", cyc, due_q.pop_front());
        end
        last_data = bus.sys_data_in;
      end else begin
        chk("data_hold", 32'(bus.sys_data_in), 32'(last_data));
      end
      if (bus.frame_done === 1'b1) got_done++;
      chk("done_pulse", 32'(prev_done & bus.frame_done), 32'd0);
      prev_we   = bus.sys_we;
      prev_done = bus.frame_done;
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"},    32'(bus.sys_we), 32'd0);
    chk({tag, "_data"},  32'(bus.sys_data_in), 32'd0);
    chk({tag, "_fv"},    32'(bus.frame_valid), 32'd0);
    chk({tag, "_done"},  32'(bus.frame_done), 32'd0);
    chk({tag, "_err"},   32'(bus.size_err), 32'd0);
  endtask

  // driver: one frame; odd_line gets odd_bytes bytes, init_line sets sdram_init_done,
  // rst_line pulses reset on byte 2 of that line, pattern puts F8 00 07 E0 at the start of line 0
  task automatic drive_frame(input int nlines, input int odd_line, input int odd_bytes,
                             input int init_line, input bit init_v, input int rst_line,
                             input bit pattern);
    bit cap;
    bit bad_sz;
    int nb;
    logic [7:0] hi;
    logic [7:0] b8;
    logic [7:0] pat [4];
    pat = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    hi = 8'd0;
    bad_sz = (nlines != H);
    repeat (2) @(negedge clk);
    chk("fv_before_fall", 32'(bus.frame_valid), 32'(m_fv));
    if (m_init) m_fidx++;
    cap = m_init && (m_fidx > SK);
    bus.cam_vsync = 1'b0;
    @(negedge clk);
    chk("fv_at_fall", 32'(bus.frame_valid), 32'(m_fv));
    if (cap) m_fv = 1'b1;
    @(negedge clk);
    chk("fv_after_fall", 32'(bus.frame_valid), 32'(m_fv));
    for (int l = 0; l < nlines; l++) begin
      nb = (l == odd_line) ? odd_bytes : 2 * W;
      if (nb != 2 * W) bad_sz = 1'b1;
      if (l == init_line) begin
        sdram_init_done = init_v;
        if (init_v) m_init = 1'b1;
      end
      for (int b = 0; b < nb; b++) begin
        @(negedge clk);
        if (pattern && l == 0 && b < 4) b8 = pat[b];
        else b8 = 8'($urandom_range(0, 255));
        bus.cam_href = 1'b1;
        bus.cam_data = b8;
        if ((b % 2) == 0) hi = b8;
        else if (cap && l < H && (b / 2) < W) begin
          exp_q.push_back({hi, b8});
          due_q.push_back(cyc + 3);
        end
        if (l == rst_line && b == 2) begin
          #1 rst = 1'b1;
          #1 chk_outputs_zero("rst_mid");
          exp_q.delete();
          due_q.delete();
          m_fv = 1'b0;
          m_err = 1'b0;
          m_fidx = 0;
          cap = 1'b0;
          m_init = sdram_init_done;
          prev_we = 1'b0;
          prev_done = 1'b0;
          last_data = 16'd0;
          #1 rst = 1'b0;
        end
      end
      @(negedge clk);
      bus.cam_href = 1'b0;
      if (l == nlines - 1) begin
        if (!tight_end) repeat ($urandom_range(1, 2)) @(negedge clk);
        bus.cam_vsync = 1'b1;
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    if (cap) begin
      m_done++;
      if (bad_sz) m_err = 1'b1;
    end
    repeat (4) @(negedge clk);
    chk("size_err", 32'(bus.size_err), 32'(m_err));
    chk("frame_done_count", got_done, m_done);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    got_we = 0;
    got_done = 0;
    prev_we = 1'b0;
    prev_done = 1'b0;
    last_data = 16'd0;
    m_init = 1'b0;
    m_fv = 1'b0;
    m_err = 1'b0;
    m_fidx = 0;
    m_done = 0;
    tight_end = 1'b0;
    rst = 1'b1;
    sdram_init_done = 1'b0;
    bus.cam_vsync = 1'b1;
    bus.cam_href = 1'b0;
    bus.cam_data = 8'd0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;

    // init held low for three frames
    repeat (3) drive_frame(H, -1, 0, -1, 1'b0, -1, 1'b0);
    chk("no_writes_before_init", got_we, 0);

    // init rises mid-frame; that frame and the next two are not written
    drive_frame(H, -1, 0, 1, 1'b1, -1, 1'b0);
    repeat (2) drive_frame(H, -1, 0, -1, 1'b0, -1, 1'b0);
    chk("no_writes_while_skipping", got_we, 0);

    // first captured frame carries the packing pattern
    drive_frame(H, -1, 0, -1, 1'b0, -1, 1'b1);
    chk("writes_first_frame", got_we, W * H);

    // init dropping is ignored; last href fall coincides with vsync rise
    tight_end = 1'b1;
    drive_frame(H, -1, 0, 0, 1'b0, -1, 1'b0);
    tight_end = 1'b0;
    chk("writes_two_frames", got_we, 2 * W * H);
    sdram_init_done = 1'b1;

    // over-long line: extra words dropped, size error
    drive_frame(H, 1, 2 * (W + 2), -1, 1'b0, -1, 1'b0);

    // async reset mid-line, re-skip, then an odd-byte line
    drive_frame(H, -1, 0, -1, 1'b0, 1, 1'b0);
    repeat (2) drive_frame(H, -1, 0, -1, 1'b0, -1, 1'b0);
    drive_frame(H, 2, 2 * W - 1, -1, 1'b0, -1, 1'b0);

    // reset again, re-skip, then a frame with one line too many
    drive_frame(H, -1, 0, -1, 1'b0, 0, 1'b0);
    repeat (2) drive_frame(H, -1, 0, -1, 1'b0, -1, 1'b0);
    drive_frame(H + 1, -1, 0, -1, 1'b0, -1, 1'b0);

    repeat (5) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
